// File: rtl/mux2x1_rr_arbiter_pkg.sv
// rtl/mux2x1_rr_arbiter_pkg.sv - arbiter state type, hold width and saturating counter helper
package mux2x1_rr_arbiter_pkg;
`include "mux2x1_arb_defs.v"

  typedef enum logic [1:0] {
    IDLE   = `MUX2X1_ARB_IDLE,
    GRANT0 = `MUX2X1_ARB_GRANT0,
    GRANT1 = `MUX2X1_ARB_GRANT1
  } arb_state_t;

  localparam int HOLD_W = `MUX2X1_ARB_HOLD_W;

  // Hold count sticks at all-ones so a long uncontended grant cannot wrap.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
    return (&h) ? h : h + HOLD_W'(1);
  endfunction
endpackage

// File: rtl/mux2x1_arb_defs.v
// rtl/mux2x1_arb_defs.v - state encodings and hold-counter width shared by the arbiter
`ifndef MUX2X1_ARB_DEFS_V
`define MUX2X1_ARB_DEFS_V
`define MUX2X1_ARB_IDLE   2'd0
`define MUX2X1_ARB_GRANT0 2'd1
`define MUX2X1_ARB_GRANT1 2'd2
`define MUX2X1_ARB_HOLD_W 8
`endif

// File: rtl/mux2x1_datapath.sv
// rtl/mux2x1_datapath.sv - combinational WIDTH-wide 2:1 mux, s=1 selects a1
module mux2x1_datapath #(
  parameter int WIDTH = 1
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] y
);
  assign y = s ? a1 : a0;
endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// rtl/mux2x1_rr_arbiter.sv - two-source round-robin arbiter with hold limit driving a registered 2:1 mux
module mux2x1_rr_arbiter
  import mux2x1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d, other_st;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_q, last_d;
  logic              s_q, s_d;
  logic              own_req, other_req;
  logic [WIDTH-1:0]  mux_y, y_q;
  logic              y_valid_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    own_req   = (state_q == GRANT1) ? req1 : req0;
    other_req = (state_q == GRANT1) ? req0 : req1;
    other_st  = (state_q == GRANT1) ? GRANT0 : GRANT1;
    case (state_q)
      IDLE: begin
        // Simultaneous requests go to whoever was not served last.
        if (req0 && req1) state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!own_req)                 state_d = other_req ? other_st : IDLE;
        else if (!other_req)          hold_d  = hold_inc(hold_q);
        else if (hold_q < HOLD_LAST)  hold_d  = hold_inc(hold_q);
        else                          state_d = other_st;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    s_d    = s_q;
    if (state_d == GRANT0) begin
      last_d = 1'b0;
      s_d    = 1'b0;
    end else if (state_d == GRANT1) begin
      last_d = 1'b1;
      s_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      s_q     <= s_d;
    end
  end

  mux2x1_datapath #(.WIDTH(WIDTH)) u_datapath (
    .s  (s_q),
    .a0 (a0),
    .a1 (a1),
    .y  (mux_y)
  );

  // y tracks the mux even when idle; y_valid marks cycles sampled under a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= mux_y;
      y_valid_q <= (state_q == GRANT0) || (state_q == GRANT1);
    end
  end

  assign gnt0    = (state_q == GRANT0);
  assign gnt1    = (state_q == GRANT1);
  assign s       = s_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// tb/tb_mux2x1_rr_arbiter.sv - scoreboard bench for mux2x1_rr_arbiter at MAX_HOLD=4 and MAX_HOLD=1
module tb_mux2x1_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_a, r1_a, r0_b, r1_b;
  logic [3:0] a0_a, a1_a, a0_b, a1_b;
  logic       g0_a, g1_a, s_a, yv_a, g0_b, g1_b, s_b, yv_b;
  logic [3:0] y_a, y_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic       sel;
    logic       g0;
    logic       g1;
    logic       s;
    logic       yv;
    logic [3:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   vec_n = 0;

  always #5 clk = ~clk;

  mux2x1_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .req0(r0_a), .req1(r1_a), .a0(a0_a), .a1(a1_a),
    .gnt0(g0_a), .gnt1(g1_a), .s(s_a), .y(y_a), .y_valid(yv_a)
  );

  mux2x1_rr_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req0(r0_b), .req1(r1_b), .a0(a0_b), .a1(a1_b),
    .gnt0(g0_b), .gnt1(g1_b), .s(s_b), .y(y_b), .y_valid(yv_b)
  );

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Drive one vector (called at a negedge) and queue the outputs expected after the next posedge.
  task automatic vec(input logic sel, input logic r0, input logic r1, input logic [3:0] d0,
                     input logic [3:0] d1, input logic eg0, input logic eg1, input logic es,
                     input logic eyv, input logic [3:0] ey);
    exp_t e;
    if (!sel) begin r0_a = r0; r1_a = r1; a0_a = d0; a1_a = d1; end
    else      begin r0_b = r0; r1_b = r1; a0_b = d0; a1_b = d1; end
    @(posedge clk);
    vec_n++;
    e.idx = vec_n; e.sel = sel; e.g0 = eg0; e.g1 = eg1; e.s = es; e.yv = eyv; e.y = ey;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per cycle; y is compared only when the DUT flags it valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          check("gnt0", e.idx, {3'b0, g0_a}, {3'b0, e.g0});
          check("gnt1", e.idx, {3'b0, g1_a}, {3'b0, e.g1});
          check("s", e.idx, {3'b0, s_a}, {3'b0, e.s});
          check("y_valid", e.idx, {3'b0, yv_a}, {3'b0, e.yv});
          if (yv_a) check("y", e.idx, y_a, e.y);
        end else begin
          check("gnt0_h1", e.idx, {3'b0, g0_b}, {3'b0, e.g0});
          check("gnt1_h1", e.idx, {3'b0, g1_b}, {3'b0, e.g1});
          check("s_h1", e.idx, {3'b0, s_b}, {3'b0, e.s});
          check("y_valid_h1", e.idx, {3'b0, yv_b}, {3'b0, e.yv});
          if (yv_b) check("y_h1", e.idx, y_b, e.y);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    r0_a = 0; r1_a = 0; a0_a = 0; a1_a = 0;
    r0_b = 0; r1_b = 0; a0_b = 0; a1_b = 0;
    repeat (2) @(negedge clk);
    check("rst_gnt0", 0, {3'b0, g0_a}, 4'h0);
    check("rst_gnt1", 0, {3'b0, g1_a}, 4'h0);
    check("rst_y_valid", 0, {3'b0, yv_a}, 4'h0);
    rst_n = 1'b1;

    // sel r0 r1 a0 a1 | gnt0 gnt1 s y_valid y
    // single requester
    vec(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 0, 4'h0);
    vec(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
    vec(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
    vec(0, 0, 0, 4'hA, 4'h5, 0, 0, 0, 1, 4'hA);
    vec(0, 0, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'h0);
    // idle fairness: last=0, so joint request goes to source 1
    vec(0, 1, 1, 4'h3, 4'hC, 0, 1, 1, 0, 4'h0);
    vec(0, 0, 1, 4'h3, 4'hC, 0, 1, 1, 1, 4'hC);
    vec(0, 0, 0, 4'h3, 4'hC, 0, 0, 1, 1, 4'hC);
    vec(0, 0, 0, 4'h3, 4'hC, 0, 0, 1, 0, 4'h0);
    // contention, 4 cycles each
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 0, 4'h0);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h6);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h6);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h6);
    vec(0, 1, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h6);
    vec(0, 1, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h9);
    vec(0, 1, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h9);
    vec(0, 1, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h9);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h9);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h6);
    // early release hands straight over to source 1
    vec(0, 0, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h6);
    vec(0, 0, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h9);
    vec(0, 0, 0, 4'h6, 4'h9, 0, 0, 1, 1, 4'h9);
    vec(0, 0, 0, 4'h6, 4'h9, 0, 0, 1, 0, 4'h0);
    // into GRANT1, then asynchronous reset
    vec(0, 0, 1, 4'h6, 4'h9, 0, 1, 1, 0, 4'h0);
    vec(0, 0, 1, 4'h6, 4'h9, 0, 1, 1, 1, 4'h9);
    #2;
    r0_a = 1'b1; r1_a = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_gnt0", 0, {3'b0, g0_a}, 4'h0);
    check("async_gnt1", 0, {3'b0, g1_a}, 4'h0);
    check("async_s", 0, {3'b0, s_a}, 4'h0);
    check("async_y", 0, y_a, 4'h0);
    check("async_y_valid", 0, {3'b0, yv_a}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // after reset last=1, so source 0 wins
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 0, 4'h0);
    vec(0, 1, 1, 4'h6, 4'h9, 1, 0, 0, 1, 4'h6);
    vec(0, 0, 0, 4'h6, 4'h9, 0, 0, 0, 1, 4'h6);
    vec(0, 0, 0, 4'h6, 4'h9, 0, 0, 0, 0, 4'h0);
    // MAX_HOLD=1: alternate every cycle
    vec(1, 1, 1, 4'h2, 4'hD, 1, 0, 0, 0, 4'h0);
    vec(1, 1, 1, 4'h2, 4'hD, 0, 1, 1, 1, 4'h2);
    vec(1, 1, 1, 4'h2, 4'hD, 1, 0, 0, 1, 4'hD);
    vec(1, 1, 1, 4'h2, 4'hD, 0, 1, 1, 1, 4'h2);
    vec(1, 1, 1, 4'h2, 4'hD, 1, 0, 0, 1, 4'hD);
    vec(1, 0, 0, 4'h2, 4'hD, 0, 0, 0, 1, 4'h2);
    vec(1, 0, 0, 4'h2, 4'hD, 0, 0, 0, 0, 4'h0);

    @(negedge clk);
    check("queue_drained", 0, (exp_q.size() == 0) ? 4'h1 : 4'h0, 4'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
